// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and stream framing.
package prog_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WR    = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_WR) || (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream, processor memory port and memory port bundled for the program loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;

  logic              p_w_en;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_start;
  logic              p_done;

  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  s_valid, s_data, p_w_en, p_addr, p_wdata, p_done,
    output s_ready, p_start, mem_w_en, mem_addr, mem_wdata
  );

  modport master (
    output s_valid, s_data, p_w_en, p_addr, p_wdata, p_done,
    input  s_ready, p_start, mem_w_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into one memory word using a 2-bit lane counter.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_vld,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        lane_q, lane_d;
  logic [DATA_W-1:0] word_q, word_d;

  always_comb begin
    lane_d    = lane_q;
    word_d    = word_q;
    word_full = 1'b0;
    if (clear) begin
      lane_d = 2'd0;
    end else if (in_vld) begin
      word_d[BYTE_W*int'(lane_q) +: BYTE_W] = in_byte;
      lane_d    = lane_q + 2'd1;
      word_full = (lane_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  // Only the lane pointer is reset; every lane is rewritten before a word is used.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q <= 2'd0;
    end else begin
      lane_q <= lane_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream into program memory, starts the processor and waits for done.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus,
  output logic           busy,
  output logic           run_done,
  output logic           err
);

  localparam int                TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              run_done_q, run_done_d;
  logic              err_q, err_d;

  logic              rdy;
  logic              pk_vld;
  logic              pk_clear;
  logic              pk_full;
  logic [DATA_W-1:0] pk_word;

  assign rdy         = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign bus.s_ready = rst & rdy;
  assign pk_vld      = (state_q == ST_LOAD) & bus.s_valid & bus.s_ready;

  prog_loader_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .in_vld    (pk_vld),
    .in_byte   (bus.s_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    tmo_d      = tmo_q;
    run_done_d = run_done_q;
    err_d      = err_q;
    pk_clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.s_valid) begin
          last_d     = ADDR_W'(bus.s_data);
          word_d     = '0;
          run_done_d = 1'b0;
          err_d      = 1'b0;
          pk_clear   = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (pk_full) state_d = ST_WR;
      end
      // The word counter stops at last, so a full 256-word load never wraps to 0.
      ST_WR: begin
        if (word_q == last_q) begin
          state_d = ST_START;
        end else begin
          word_d  = word_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.p_done) begin
          run_done_d = 1'b1;
          state_d    = ST_DONE;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          run_done_d = 1'b1;
          err_d      = 1'b1;
          state_d    = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      last_q     <= '0;
      tmo_q      <= '0;
      run_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
      run_done_q <= run_done_d;
      err_q      <= err_d;
    end
  end

  // Loader owns the memory port only while loading; the processor sees it otherwise.
  always_comb begin
    bus.mem_w_en  = bus.p_w_en;
    bus.mem_addr  = bus.p_addr;
    bus.mem_wdata = bus.p_wdata;
    if (!rst) begin
      bus.mem_w_en  = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
    end else if ((state_q == ST_LOAD) || (state_q == ST_WR)) begin
      bus.mem_w_en  = (state_q == ST_WR);
      bus.mem_addr  = word_q;
      bus.mem_wdata = pk_word;
    end
  end

  assign bus.p_start = (state_q == ST_START);
  assign busy        = state_is_busy(state_q);
  assign run_done    = run_done_q;
  assign err         = err_q;

endmodule
